// File: rtl/alu_mul_sequencer.sv
// alu_mul_sequencer: multi-cycle shift-and-add multiplier producing a
// WIDTH-bit truncated product. There is no private adder. Every partial
// product addition is borrowed from the shared datapath ALU through a
// req/gnt handshake. The block stalls for as long as the grant is withheld.
// The truncated product is the same for signed and unsigned operands, so no
// sign handling is needed.
module alu_mul_sequencer #(
  parameter int WIDTH      = 16,
  parameter int EARLY_EXIT = 1
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             START,
  input  logic [WIDTH-1:0] OP_A,
  input  logic [WIDTH-1:0] OP_B,
  output logic             READY,
  output logic             DONE,
  output logic [WIDTH-1:0] RESULT,
  output logic             ALU_REQ,
  input  logic             ALU_GNT,
  output logic [1:0]       ALUK,
  output logic [WIDTH-1:0] ALU_A,
  output logic [WIDTH-1:0] ALU_B,
  input  logic [WIDTH-1:0] ALU_OUT
);

  // Iteration counter must be able to hold the value WIDTH itself.
  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [1:0] ALUK_ADD   = 2'b00;
  localparam logic [1:0] ALUK_PASSA = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q,  state_d;
  logic [WIDTH-1:0] acc_q,    acc_d;
  logic [WIDTH-1:0] mcand_q,  mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CW-1:0]    cnt_q,    cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             done_q,   done_d;

  logic             run_term;
  logic             alu_req;

  // Terminating condition for the RUN state. Either every bit position has
  // been consumed, or (with early exit) no set multiplier bits remain.
  always_comb begin
    run_term = (cnt_q == CW'(WIDTH)) ||
               ((EARLY_EXIT != 0) && (mplier_q == '0));
  end

  // The ALU is needed only in a non-terminating RUN cycle whose current
  // multiplier bit is set. This is derived purely from registered state, so
  // the request and the ALU operands change only on clock edges.
  always_comb begin
    alu_req = (state_q == S_RUN) && !run_term && mplier_q[0];
  end

  // Next-state and datapath update logic.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (START) begin
          mcand_d  = OP_A;
          mplier_d = OP_B;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = S_RUN;
        end
      end

      S_RUN: begin
        if (run_term) begin
          // RESULT and DONE are loaded together so that DONE is high
          // exactly while the new RESULT is first visible.
          result_d = acc_q;
          done_d   = 1'b1;
          state_d  = S_DONE;
        end else if (mplier_q[0]) begin
          // Add cycle. Advance only when the ALU is ours. Otherwise hold
          // every register, which keeps ALU_A/ALU_B stable while we wait.
          if (ALU_GNT) begin
            acc_d    = ALU_OUT;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CW'(1);
          end
        end else begin
          // Skip cycle. There is nothing to add, so only shift.
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + CW'(1);
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, datapath and output registers. Reset aborts any operation in
  // flight and also clears RESULT.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  // Outputs. The ALU operands are forced to a quiet PASSA of zero whenever
  // the ALU is not being requested, so they never disturb the shared bus.
  assign READY   = (state_q == S_IDLE);
  assign DONE    = done_q;
  assign RESULT  = result_q;
  assign ALU_REQ = alu_req;
  assign ALUK    = alu_req ? ALUK_ADD : ALUK_PASSA;
  assign ALU_A   = alu_req ? acc_q    : '0;
  assign ALU_B   = alu_req ? mcand_q  : '0;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Bench for alu_mul_sequencer. Two instances share clock and reset:
// instance 0 uses EARLY_EXIT=1 and instance 1 uses EARLY_EXIT=0. A
// scoreboard entry (product, latency, add count, request count) is pushed
// when a START is driven. It is popped and compared when DONE pulses.
module tb_alu_mul_sequencer;

  typedef struct {
    logic [15:0] res;
    int          t0;
    int          lat;
    int          adds;
    int          reqs;
  } sb_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start   [2];
  logic [15:0] op_a    [2];
  logic [15:0] op_b    [2];
  logic        ready   [2];
  logic        done    [2];
  logic [15:0] result  [2];
  logic        alu_req [2];
  logic        gnt     [2];
  logic [1:0]  aluk    [2];
  logic [15:0] alu_a   [2];
  logic [15:0] alu_b   [2];
  logic [15:0] alu_out [2];
  int          stall_cfg [2];

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_inst
    sb_t         q[$];
    int          stall_used = 0;
    int          n_req = 0;
    int          n_add = 0;
    logic        prev_stall = 1'b0;
    logic [15:0] prev_a = '0;
    logic [15:0] prev_b = '0;

    alu_mul_sequencer #(.WIDTH(16), .EARLY_EXIT(gi == 0 ? 1 : 0)) dut (
      .CLK     (clk),
      .RESET_N (rst_n),
      .START   (start[gi]),
      .OP_A    (op_a[gi]),
      .OP_B    (op_b[gi]),
      .READY   (ready[gi]),
      .DONE    (done[gi]),
      .RESULT  (result[gi]),
      .ALU_REQ (alu_req[gi]),
      .ALU_GNT (gnt[gi]),
      .ALUK    (aluk[gi]),
      .ALU_A   (alu_a[gi]),
      .ALU_B   (alu_b[gi]),
      .ALU_OUT (alu_out[gi])
    );

    // Behavioural shared ALU: ADD or PASSA.
    assign alu_out[gi] = (aluk[gi] == 2'b00) ? 16'(alu_a[gi] + alu_b[gi]) : alu_a[gi];
    // Deny the first stall_cfg requesting cycles of each operation.
    assign gnt[gi] = (stall_used >= stall_cfg[gi]);

    always @(posedge clk) begin
      if (start[gi] && ready[gi]) stall_used <= 0;
      else if (alu_req[gi] && !gnt[gi]) stall_used <= stall_used + 1;
    end

    always @(negedge clk) begin
      if (!rst_n) begin
        q.delete();
        n_req = 0;
        n_add = 0;
        prev_stall = 1'b0;
      end else begin
        check($sformatf("aluk%0d", gi), {30'd0, aluk[gi]}, alu_req[gi] ? 32'd0 : 32'd3);
        if (!alu_req[gi]) check($sformatf("alu_a_idle%0d", gi), {16'd0, alu_a[gi]}, 32'd0);
        if (prev_stall) begin
          check($sformatf("stall_req%0d", gi), {31'd0, alu_req[gi]}, 32'd1);
          check($sformatf("stall_a%0d", gi), {16'd0, alu_a[gi]}, {16'd0, prev_a});
          check($sformatf("stall_b%0d", gi), {16'd0, alu_b[gi]}, {16'd0, prev_b});
        end
        prev_stall = alu_req[gi] && !gnt[gi];
        prev_a = alu_a[gi];
        prev_b = alu_b[gi];
        if (alu_req[gi]) begin
          n_req++;
          if (gnt[gi]) n_add++;
        end
        if (done[gi]) begin
          check($sformatf("ready_in_done%0d", gi), {31'd0, ready[gi]}, 32'd0);
          if (q.size() == 0) begin
            check($sformatf("unexpected_done%0d", gi), 32'd1, 32'd0);
          end else begin
            sb_t e;
            e = q.pop_front();
            check($sformatf("result%0d", gi), {16'd0, result[gi]}, {16'd0, e.res});
            check($sformatf("latency%0d", gi), cyc - e.t0, e.lat);
            check($sformatf("adds%0d", gi), n_add, e.adds);
            check($sformatf("reqs%0d", gi), n_req, e.reqs);
            $display("inst%0d result=0x%04h latency=%0d adds=%0d", gi, result[gi], cyc - e.t0, n_add);
          end
          n_req = 0;
          n_add = 0;
        end
      end
    end
  end

  function automatic int qsize(input int i);
    return (i == 0) ? g_inst[0].q.size() : g_inst[1].q.size();
  endfunction

  // Drive one multiply on instance i and record what the DUT must produce.
  task automatic mul(input int i, input logic [15:0] a, input logic [15:0] b, input int stalls);
    sb_t e;
    int  k, pc, se, guard;
    guard = 0;
    while (!ready[i] && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!ready[i]) begin
      check("ready_timeout", 32'd0, 32'd1);
      return;
    end
    k = 0;
    pc = 0;
    for (int j = 0; j < 16; j++) begin
      if (b[j]) begin
        k = j + 1;
        pc++;
      end
    end
    se = (pc > 0) ? stalls : 0;
    e.res  = 16'(a * b);
    e.t0   = cyc;
    e.lat  = ((i == 0) ? k + 2 : 18) + se;
    e.adds = pc;
    e.reqs = pc + se;
    stall_cfg[i] = stalls;
    op_a[i] = a;
    op_b[i] = b;
    start[i] = 1'b1;
    if (i == 0) g_inst[0].q.push_back(e);
    else        g_inst[1].q.push_back(e);
    @(negedge clk);
    start[i] = 1'b0;
  endtask

  // Wait (bounded) until every expected result of instance i has appeared.
  task automatic drain(input int i);
    int guard;
    guard = 0;
    while ((qsize(i) != 0 || !ready[i]) && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (qsize(i) != 0) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_reset_outputs(input int i);
    check("rst_ready", {31'd0, ready[i]}, 32'd1);
    check("rst_done", {31'd0, done[i]}, 32'd0);
    check("rst_result", {16'd0, result[i]}, 32'd0);
    check("rst_req", {31'd0, alu_req[i]}, 32'd0);
    check("rst_aluk", {30'd0, aluk[i]}, 32'd3);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      start[i] = 1'b0;
      op_a[i] = '0;
      op_b[i] = '0;
      stall_cfg[i] = 0;
    end
    repeat (3) @(negedge clk);
    check_reset_outputs(0);
    check_reset_outputs(1);
    rst_n = 1'b1;
    @(negedge clk);

    // Early-exit instance: directed cases.
    mul(0, 16'd3, 16'd5, 0);          drain(0);
    mul(0, 16'h1234, 16'h0000, 0);    drain(0);
    mul(0, 16'hFFFF, 16'hFFFF, 0);    drain(0);
    mul(0, 16'h8000, 16'h0002, 0);    drain(0);
    mul(0, 16'd7, 16'd3, 4);          drain(0);

    // START while busy is ignored, then a back-to-back START right after DONE.
    mul(0, 16'd11, 16'd13, 0);
    @(negedge clk);
    op_a[0] = 16'd9;
    op_b[0] = 16'd9;
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    mul(0, 16'd6, 16'd7, 0);
    drain(0);

    // Asynchronous reset in the middle of a long run.
    mul(0, 16'h00FF, 16'h00FF, 0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs(0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mul(0, 16'd2, 16'd2, 0);          drain(0);

    // Fixed-length instance.
    mul(1, 16'h1234, 16'h0000, 0);    drain(1);
    mul(1, 16'd3, 16'd5, 0);          drain(1);
    mul(1, 16'hFFFF, 16'hFFFF, 2);    drain(1);

    // Random operands and stalls on both instances.
    for (int n = 0; n < 8; n++) begin
      logic [15:0] a, b;
      a = 16'($urandom);
      b = 16'($urandom) >> $urandom_range(0, 15);
      mul(n % 2, a, b, $urandom_range(0, 3));
      drain(n % 2);
    end

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/alu_mul_sequencer.md
Name: alu_mul_sequencer

Overview:
- Multi-cycle shift-and-add multiplier that produces a 16-bit truncated product. It performs every addition on the shared datapath ALU with the ADD operation, ALUK=2'b00.
- The block requests the ALU through a req/gnt handshake because the main datapath also uses the ALU. It stalls when the grant is withheld.
- It provides an LC-3 extension multiply without adding a second adder.
- The truncated product is identical for signed and unsigned two's-complement operands.

Parameters:
- WIDTH, 16, operand, product and ALU data width.
- EARLY_EXIT, 1, when 1 the operation terminates as soon as the remaining multiplier bits are all zero. When 0 it always runs WIDTH iterations.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RESET_N  input  1  asynchronous active-low reset.
- START  input  1  pulse requesting a multiply; sampled only when READY=1.
- OP_A  input  WIDTH  multiplicand, captured at accepted START.
- OP_B  input  WIDTH  multiplier, captured at accepted START.
- READY  output  1  block is idle and can accept START.
- DONE  output  1  one-cycle pulse: RESULT has been updated.
- RESULT  output  WIDTH  product modulo 2^WIDTH; holds until the next DONE.
- ALU_REQ  output  1  requests the shared ALU for the current cycle.
- ALU_GNT  input  1  the ALU is granted to this block this cycle; it is only meaningful while ALU_REQ=1.
- ALUK  output  2  ALU operation select: 2'b00 (ADD) while ALU_REQ=1, otherwise 2'b11 (PASSA).
- ALU_A  output  WIDTH  ALU A input: ACC while ALU_REQ=1, otherwise 0.
- ALU_B  output  WIDTH  ALU B input: MCAND while ALU_REQ=1, otherwise 0.
- ALU_OUT  input  WIDTH  combinational ALU result, sampled in the same cycle as the grant.

Behaviour:
- Clock and reset: one clock domain, CLK. Reset is asynchronous and active-low on RESET_N.
- Reset values: state=IDLE; ACC, MCAND, MPLIER and CNT are 0; RESULT=0; DONE=0; ALU_REQ=0; READY=1.
- Reset asserted mid-operation aborts immediately. No DONE is issued and RESULT is cleared to 0.
- Internal registers:
  - ACC, WIDTH bits.
  - MCAND, WIDTH bits; shifts left, zero fill, and bits shifted out are lost.
  - MPLIER, WIDTH bits; shifts right logically.
  - CNT, clog2(WIDTH)+1 bits.
- States:
  - IDLE: READY=1. START=1 loads MCAND=OP_A and MPLIER=OP_B, clears ACC and CNT, and moves to RUN. START is ignored in every other state.
  - RUN, checked in priority order each cycle:
    - (a) If CNT==WIDTH, or EARLY_EXIT=1 and MPLIER==0: move to DONE with no ALU request.
    - (b) Else if MPLIER[0]=1: assert ALU_REQ. If ALU_GNT=1: ACC<=ALU_OUT, MCAND<<=1, MPLIER>>=1, CNT+=1. If ALU_GNT=0: hold all registers (stall) and keep requesting.
    - (c) Else (MPLIER[0]=0): MCAND<<=1, MPLIER>>=1, CNT+=1, with no ALU request.
  - DONE: RESULT<=ACC is registered on the transition into DONE. DONE=1 for exactly this one cycle, then return to IDLE. READY=0 during DONE, so the earliest next START is accepted one cycle after DONE.
- ALU_REQ is a Moore output. It is combinational from state and MPLIER[0], and is never asserted in IDLE or DONE or in the terminating RUN cycle.
- ALU_REQ, ALUK, ALU_A and ALU_B change only on clock edges.
- ALU_OUT is used only in granted cycles. Overflow beyond WIDTH bits is silently discarded.
- Latency with EARLY_EXIT=1 and no stalls:
  - k = index of the highest set bit of OP_B, plus 1 (k=0 for OP_B=0).
  - RUN lasts k+1 cycles, so DONE is high k+2 cycles after the START edge.
- Latency with EARLY_EXIT=0: RUN always lasts WIDTH+1 cycles, plus stall cycles.
- Each stall cycle, i.e. a cycle with ALU_GNT=0 while requesting, adds exactly one cycle.

Test Plan:
- Basic multiply: OP_A=3, OP_B=5, ALU_GNT tied 1 → ALU_REQ high in RUN cycles 1 and 3 only; DONE 5 cycles after START; RESULT=0x000F.
- Zero multiplier: OP_A=0x1234, OP_B=0, EARLY_EXIT=1 → no ALU_REQ; DONE 2 cycles after START; RESULT=0x0000. With EARLY_EXIT=0 → DONE 18 cycles after START.
- Wrap-around: OP_A=0xFFFF, OP_B=0xFFFF → 16 granted ALU ADDs; RESULT=0x0001. OP_A=0x8000, OP_B=2 → RESULT=0x0000.
- Grant stalls: OP_A=7, OP_B=3, ALU_GNT=0 for the first 4 requesting cycles → ALU_REQ held with ALU_A/ALU_B stable; DONE delayed by exactly 4 cycles; RESULT=0x0015.
- Start while busy / back-to-back: a second START mid-RUN with different operands is ignored and RESULT equals the first product. A START in the cycle after DONE is accepted.
- Reset mid-RUN: drop RESET_N asynchronously during RUN of 0x00FF×0x00FF → outputs return to reset values immediately with no DONE; after release, a new 2×2 multiply yields RESULT=0x0004.
